// File: rtl/uart_tx_fifo_if.sv
// Bus-side and uart_tx-side signals of the buffered UART transmit front-end.
// master drives pushes and uart_tx busy; slave is the FIFO/launcher itself.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  push;
  logic [7:0]            push_data;
  logic                  flush;
  logic                  clear_ovf;
  logic                  tx_busy;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  irq_low;
  logic                  active;

  modport master (
    output push, push_data, flush, clear_ovf, tx_busy,
    input  tx_start, tx_data, level, full, empty, overflow, irq_low, active
  );

  modport slave (
    input  push, push_data, flush, clear_ovf, tx_busy,
    output tx_start, tx_data, level, full, empty, overflow, irq_low, active
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: bus pushes fill a circular FIFO and a
// small launcher FSM feeds uart_tx one byte at a time.
//
//   state  | meaning
//   IDLE   | waiting for a queued byte and uart_tx not busy
//   LAUNCH | tx_start pulse cycle, byte already popped
//   GUARD  | one cycle for uart_tx's registered busy to rise
//   WAIT   | byte in flight, waiting for tx_busy to fall
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int LOW_WATER  = 2
) (
  input  logic           clk,
  input  logic           rstn,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LOW_L   = (DEPTH_LOG2 + 1)'(LOW_WATER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    GUARD  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  drop;
  logic                  launch;
  logic                  tx_start_q;
  logic [7:0]            tx_data_q;
  logic                  overflow_q;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  // Flush discards a same-cycle push outright, so it never counts as a drop.
  always_comb begin
    push_ok = bus.push && !full && !bus.flush;
    drop    = bus.push && full && !bus.flush;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.tx_busy && !bus.flush) begin
          launch     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:  state_next = GUARD;
      GUARD:   state_next = WAIT;
      WAIT: begin
        if (!bus.tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= bus.push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (launch) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, launch})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // tx_data is only reloaded on a launch so uart_tx sees a stable byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= launch;
      if (launch) begin
        tx_data_q <= mem[rptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.level    = level_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.irq_low  = (level_q <= LOW_L) &&
                        (((state == IDLE) && !bus.tx_busy) || (level_q != '0));
  assign bus.active   = (state != IDLE) || bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus randomized bench for uart_tx_fifo with a queue scoreboard
// and a simple uart_tx busy model.
module tb_uart_tx_fifo;
  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int LW    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(DL), .LOW_WATER(LW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  logic        hold_busy = 1'b0;
  int unsigned busy_len  = 10;
  int unsigned ucnt;

  // uart_tx stand-in: busy rises the edge after it samples tx_start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ucnt <= 0;
    else if (bus.tx_start) ucnt <= busy_len;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign bus.tx_busy = hold_busy || (ucnt != 0);

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] byte_q [$];
  logic       exp_ovf    = 1'b0;
  logic [7:0] last_data  = 8'h00;
  logic       prev_start = 1'b0;
  int         n_starts   = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input bit p, input logic [7:0] d, input bit f, input bit c);
    int  pre;
    int  exp_b;
    bit  drop;
    bus.push      = p;
    bus.push_data = d;
    bus.flush     = f;
    bus.clear_ovf = c;
    pre = byte_q.size();
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_ovf = 1'b0;
    if (bus.tx_start) begin
      n_starts++;
      check("start_width", int'(prev_start), 0);
      exp_b = (byte_q.size() != 0) ? int'(byte_q.pop_front()) : 'h100;
      check("tx_data", int'(bus.tx_data), exp_b);
      last_data = exp_b[7:0];
    end else begin
      check("tx_hold", int'(bus.tx_data), int'(last_data));
    end
    drop = 1'b0;
    if (f) byte_q.delete();
    else if (p) begin
      if (pre == DEPTH) drop = 1'b1;
      else byte_q.push_back(d);
    end
    exp_ovf = drop ? 1'b1 : (c ? 1'b0 : exp_ovf);
    check("level", int'(bus.level), byte_q.size());
    check("full", int'(bus.full), int'(byte_q.size() == DEPTH));
    check("empty", int'(bus.empty), int'(byte_q.size() == 0));
    check("overflow", int'(bus.overflow), int'(exp_ovf));
    if (byte_q.size() != 0) check("irq_low", int'(bus.irq_low), int'(byte_q.size() <= LW));
    else check("irq_idle", int'(bus.irq_low), int'(!bus.active));
    if (bus.tx_busy) check("active_busy", int'(bus.active), 1);
    prev_start = bus.tx_start;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((byte_q.size() != 0 || bus.active) && k < budget) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      k++;
    end
    check("drain_timeout", int'(k < budget), 1);
  endtask

  task automatic check_reset_state();
    check("rst_level", int'(bus.level), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_overflow", int'(bus.overflow), 0);
  endtask

  task automatic model_reset();
    byte_q.delete();
    exp_ovf    = 1'b0;
    last_data  = 8'h00;
    prev_start = 1'b0;
  endtask

  initial begin
    int s0;
    int pushed;
    bus.push = 1'b0; bus.push_data = 8'h00; bus.flush = 1'b0; bus.clear_ovf = 1'b0;
    #1;
    check_reset_state();
    check("rst_active", int'(bus.active), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Single byte latency, then a long uart_tx busy with 5 bytes queued.
    busy_len = 1200;
    step(1'b1, 8'h41, 1'b0, 1'b0);
    check("lat_e1", int'(bus.tx_start), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lat_e2", int'(bus.tx_start), 1);
    check("lat_data", int'(bus.tx_data), 'h41);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pulse_end", int'(bus.tx_start), 0);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("no_second_start", n_starts, 1);
    check("queued5", int'(bus.level), 5);
    rstn = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Fill under held busy, overflow on 9th, ordered drain.
    busy_len = 20;
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    check("fill_full", int'(bus.full), 1);
    check("fill_level", int'(bus.level), 8);
    step(1'b1, 8'h38, 1'b0, 1'b0);
    check("ovf9", int'(bus.overflow), 1);
    check("ovf9_level", int'(bus.level), 8);
    s0 = n_starts;
    hold_busy = 1'b0;
    drain(2000);
    check("fill_emitted", n_starts - s0, 8);

    // Push while full in the same cycle as a pop launch.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    hold_busy = 1'b0;
    step(1'b1, 8'h68, 1'b0, 1'b0);
    check("pop_push_level", int'(bus.level), 7);
    check("pop_push_ovf", int'(bus.overflow), 1);
    check("pop_push_start", int'(bus.tx_start), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_ovf", int'(bus.overflow), 0);
    step(1'b1, 8'h69, 1'b0, 1'b0);
    step(1'b1, 8'h6a, 1'b0, 1'b1);
    check("clear_vs_drop", int'(bus.overflow), 1);
    drain(2000);

    // Flush with a concurrent push while a byte is in flight.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    busy_len = 50;
    for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    check("pre_flush_level", int'(bus.level), 6);
    s0 = n_starts;
    step(1'b1, 8'haa, 1'b1, 1'b0);
    check("flush_level", int'(bus.level), 0);
    check("flush_ovf", int'(bus.overflow), 0);
    check("flush_active", int'(bus.active), 1);
    drain(500);
    check("flush_no_start", n_starts - s0, 0);

    // Pointer wrap: 20 bytes with level held at or below 5.
    busy_len = 6;
    s0 = n_starts;
    pushed = 0;
    while (pushed < 20) begin
      if (byte_q.size() < 5 && $urandom_range(0, 3) != 0) begin
        step(1'b1, 8'(pushed), 1'b0, 1'b0);
        pushed++;
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    drain(2000);
    check("wrap_emitted", n_starts - s0, 20);

    // Randomized mix of pushes, flushes, clears and external busy.
    for (int i = 0; i < 600; i++) begin
      hold_busy = ($urandom_range(0, 9) == 0);
      busy_len  = $urandom_range(1, 8);
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 10) == 0));
    end
    hold_busy = 1'b0;
    drain(3000);
    check("final_empty", int'(bus.empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered transmit front-end between the tinyQV peripheral bus decode and uart_tx.
- Bus writes to the UART data register push bytes into a DEPTH-entry FIFO.
- A small FSM pops bytes and launches them into uart_tx one at a time, so the CPU no longer spins on uart_tx_busy.
- Provides level, full/empty, sticky overflow and a low-water interrupt for the interrupt_req vector.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (DEPTH = 8 entries); legal range 1..6.
- LOW_WATER, 2, irq_low asserts while level <= LOW_WATER; must be < 2^DEPTH_LOG2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- push  in  1  one-cycle write strobe (bus write_n != 2'b11 and data address decoded).
- push_data  in  8  byte to enqueue (data_to_write[7:0]).
- flush  in  1  synchronous FIFO clear.
- clear_ovf  in  1  clears the sticky overflow flag.
- tx_busy  in  1  uart_tx_busy from uart_tx.
- tx_start  out  1  uart_tx_en to uart_tx; registered.
- tx_data  out  8  uart_tx_data to uart_tx; registered.
- level  out  DEPTH_LOG2+1  number of queued bytes, excluding the byte in flight.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; set when a push is dropped.
- irq_low  out  1  level <= LOW_WATER and FSM in IDLE with tx_busy low, or level <= LOW_WATER with level != 0.
- active  out  1  FSM not IDLE, or tx_busy high.

Behaviour:
- Reset (async assert, clean sync release) forces:
  - state = IDLE, read/write pointers = 0, level = 0, empty = 1, full = 0.
  - tx_start = 0, tx_data = 8'h00, overflow = 0.
  - FIFO storage needs no reset.
- Storage is circular. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Level is a separate counter, DEPTH_LOG2+1 bits.
- Push:
  - Accepted when full == 0 at the clock edge. Writes mem[wptr], increments wptr and level.
  - When full == 1, the byte is dropped and overflow is set. A simultaneous pop does not rescue it.
- Pop: occurs only on the IDLE->LAUNCH transition, and only if empty == 0.
- Simultaneous accepted push and pop leaves level unchanged; both pointers advance.
- flush:
  - Sets pointers and level to 0. Overrides a same-cycle push, which is discarded without setting overflow.
  - Does not abort a byte already launched, and does not change the FSM state.
- clear_ovf clears overflow. A same-cycle overflow event wins, so overflow stays 1.
- FSM:
  - IDLE: if !empty && !tx_busy && !flush then tx_data <= mem[rptr], tx_start <= 1, pop, go to LAUNCH.
  - LAUNCH: tx_start <= 0, go to GUARD. tx_start is high for exactly one cycle.
  - GUARD: unconditional one cycle, covering uart_tx's registered busy. Go to WAIT.
  - WAIT: when tx_busy == 0, go to IDLE.
- Latency: push at edge E0 -> tx_start high in the cycle after E1 (one cycle later), provided the FSM is IDLE and tx_busy is low.
- Back-to-back bytes: the next launch occurs no earlier than the first IDLE cycle after tx_busy falls.
- tx_data holds its value until the next launch.
- tx_busy high in IDLE (e.g. a direct uart_tx user) blocks launch; the FIFO just fills.
- Reset mid-transmission: the FIFO is lost and tx_start drops immediately. uart_tx resets from the same rstn.

Test Plan:
- Reset with rstn=0 mid-WAIT containing 5 queued bytes -> level=0, empty=1, tx_start=0, tx_data=8'h00 immediately, without waiting for a clock edge.
- Single push 8'h41 into empty FIFO (tx_busy=0) -> tx_start=1, tx_data=8'h41 exactly one cycle after the push edge, high for 1 cycle. Model uart_tx busy for 1200 cycles -> no second tx_start.
- Push 8'h30..8'h37 back-to-back while tx_busy=1 held -> full=1 and level=8 after the 8th push. 9th push 8'h38 -> overflow=1, level stays 8. Release busy -> bytes emitted in order 30..37, 38 never emitted.
- Push with the FIFO full in the same cycle as a pop launch -> push dropped, overflow=1, level=7. Then clear_ovf -> overflow=0. clear_ovf coincident with another dropped push -> overflow stays 1.
- Fill 6 bytes then flush with a concurrent push 8'hAA -> level=0, overflow=0, in-flight byte completes, FSM returns to IDLE with no further tx_start.
- Pointer wrap: stream 20 bytes 8'h00..8'h13 with level peaking at 5 -> output sequence identical and in order. irq_low toggles high whenever 1 <= level <= 2.
